serial_deserializer: RTL and testbench
======================================

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits (WIDTH >= 2).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: bit_en  input  1  bit-period strobe; sin is sampled only on edges where bit_en=1.
REQ-005 Port: sin  input  1  serial line; idle high; frame = start(0), WIDTH data bits LSB first, stop(1).
REQ-006 Port: out  output  WIDTH  last correctly framed word; feeds a register-bank stage's in port.
REQ-007 Port: wr_en  output  1  one-cycle strobe marking out as new; feeds the register-bank stage's wr_en port.
REQ-008 Port: busy  output  1  high while a frame is in progress (state != IDLE).
REQ-009 Port: frame_err  output  1  one-cycle pulse on stop-bit violation.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, DATA, STOP.
REQ-011 In IDLE, on an edge with bit_en=1 and sin=0, the FSM SHALL go to DATA and clear the bit counter; sin=1 or bit_en=0 SHALL keep it in IDLE.
REQ-012 In DATA, on each bit_en=1 edge, the block SHALL shift sin into the MSB of an internal WIDTH-bit shift register (shift right), so the first data bit lands in bit 0 after WIDTH shifts.
REQ-013 The bit counter SHALL be $clog2(WIDTH) bits wide, SHALL increment on each DATA sample, and SHALL move the FSM to STOP on the sample taken while counter == WIDTH-1.
REQ-014 In STOP, on a bit_en=1 edge with sin=1, the block SHALL load out from the shift register and assert wr_en for exactly the following cycle, then return to IDLE.
REQ-015 In STOP, on a bit_en=1 edge with sin=0, the block SHALL leave out unchanged, assert frame_err for exactly the following cycle, keep wr_en low, and return to IDLE.
REQ-016 Cycles with bit_en=0 SHALL change no state, counter, shift register, or output other than clearing wr_en and frame_err pulses.
REQ-017 wr_en and frame_err SHALL be registered, SHALL never be high together, and SHALL never stay high for two consecutive cycles.
REQ-018 A start bit SHALL be accepted on the first bit_en edge after the stop bit, so back-to-back frames with no idle bits are received without loss.
REQ-019 out SHALL hold its value between frames and SHALL change only on the wr_en-producing edge.
REQ-020 busy SHALL be combinational from state: 1 in DATA and STOP, 0 in IDLE.

Reset
REQ-021 On a clk edge with rst=1, state SHALL become IDLE, counter and shift register 0, out = 0, wr_en = 0, frame_err = 0.
REQ-022 rst SHALL take priority over bit_en and sin, and SHALL abort any partial frame with no wr_en or frame_err emitted.

Structure
REQ-023 A shared package ser_pkg SHALL hold the state_t enum (IDLE, DATA, STOP) and the DEFAULT_WIDTH = 8 constant.
REQ-024 The block SHALL be a single module with no sub-modules; the bench SHALL instantiate it driving a register_bank of equal WIDTH (out->in, wr_en->wr_en).

Verification
REQ-025 bit_en=1 every cycle, frame 0xA5 (sin: 0,1,0,1,0,0,1,0,1,1) -> out=8'hA5, wr_en high exactly one cycle after the stop sample, downstream register holds 8'hA5.
REQ-026 After 0xA5, frame 0x3C with stop bit 0 -> frame_err one-cycle pulse, wr_en stays 0, out stays 8'hA5.
REQ-027 bit_en high one cycle in four, frame 0x5A -> out=8'h5A, single wr_en pulse, busy high from the start-sample edge to the stop-sample edge.
REQ-028 rst=1 for one cycle after 4 data bits of 0xFF -> busy=0, out=8'h00, no pulses; next frame 0xFA -> out=8'hFA.
REQ-029 Back-to-back frames 0x0F then 0xF0 with no idle bits -> two wr_en pulses, out=8'h0F then 8'hF0.
REQ-030 sin held 1 with bit_en=1 for 20 cycles -> state stays IDLE, busy=0, no wr_en or frame_err.

Source files
------------

// File: rtl/ser_pkg.sv
// ser_pkg: shared deserializer state encoding and default word width
package ser_pkg;
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/register_bank.sv
// register_bank: single-word holding register loaded on wr_en
module register_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             wr_en,
  output logic [WIDTH-1:0] out
);
  always_ff @(posedge clk)
    if (rst) out <= '0;
    else if (wr_en) out <= in;
endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: start/LSB-first data/stop frame receiver with word strobe and framing-error pulse
module serial_deserializer
  import ser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             sin,
  output logic [WIDTH-1:0] out,
  output logic             wr_en,
  output logic             busy,
  output logic             frame_err
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n, out_n;
  logic wr_n, fe_n;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      out       <= '0;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sr        <= sr_n;
      out       <= out_n;
      wr_en     <= wr_n;
      frame_err <= fe_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    out_n   = out;
    wr_n    = 1'b0;
    fe_n    = 1'b0;
    if (bit_en)
      case (state)
        IDLE: begin
          state_n = sin ? IDLE : DATA;
          cnt_n   = sin ? cnt : '0;
        end
        DATA: begin
          sr_n    = {sin, sr[WIDTH-1:1]};
          cnt_n   = cnt + 1'b1;
          state_n = cnt == LAST ? STOP : DATA;
        end
        STOP: begin
          state_n = IDLE;
          out_n   = sin ? sr : out;
          wr_n    = sin;
          fe_n    = !sin;
        end
        default: state_n = IDLE;
      endcase
  end
endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: randomized frame-level checking of the deserializer feeding a register bank
module tb_serial_deserializer;
  localparam int W = 8;
  logic clk, rst, bit_en, sin;
  logic [W-1:0] out, reg_q, exp_out;
  logic wr_en, busy, frame_err;
  int n_cmp = 0;
  int n_err = 0;
  serial_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin),
    .out(out), .wr_en(wr_en), .busy(busy), .frame_err(frame_err)
  );
  register_bank #(.WIDTH(W)) rb (
    .clk(clk), .rst(rst), .in(out), .wr_en(wr_en), .out(reg_q)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask
  task automatic tick(input logic en, input logic b, input logic ew, input logic ef,
                      input logic eb, input logic [W-1:0] eo);
    logic [W-1:0] prev;
    prev    = exp_out;
    exp_out = eo;
    bit_en  = en;
    sin     = b;
    @(posedge clk);
    #1;
    check("wr_en", W'(wr_en), W'(ew));
    check("frame_err", W'(frame_err), W'(ef));
    check("busy", W'(busy), W'(eb));
    check("out", out, exp_out);
    check("reg_bank", reg_q, prev);
  endtask
  task automatic send_frame(input logic [W-1:0] d, input logic stop, input int gap);
    logic [W+1:0] bits;
    bits = {stop, d, 1'b0};
    for (int k = 0; k < W + 2; k++) begin
      for (int g = 1; g < gap; g++) tick(1'b0, 1'($urandom), 1'b0, 1'b0, k > 0, exp_out);
      if (k == W + 1)
        tick(1'b1, bits[k], stop, !stop, 1'b0, stop ? d : exp_out);
      else
        tick(1'b1, bits[k], 1'b0, 1'b0, 1'b1, exp_out);
    end
  endtask
  task automatic do_reset();
    rst    = 1'b1;
    bit_en = 1'($urandom);
    sin    = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_out = '0;
    check("rst_busy", W'(busy), W'(0));
    check("rst_out", out, '0);
    check("rst_wr_en", W'(wr_en), W'(0));
    check("rst_frame_err", W'(frame_err), W'(0));
    check("rst_reg_bank", reg_q, '0);
  endtask
  initial begin
    rst = 1'b0; bit_en = 1'b0; sin = 1'b1; exp_out = '0;
    do_reset();
    repeat (20) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_out);
    send_frame(8'hA5, 1'b1, 1);
    check("after_a5", out, 8'hA5);
    send_frame(8'h3C, 1'b0, 1);
    check("after_3c_err", out, 8'hA5);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_out);
    send_frame(8'h5A, 1'b1, 4);
    check("after_5a", out, 8'h5A);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_out);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp_out);
    repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, exp_out);
    do_reset();
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_out);
    send_frame(8'hFA, 1'b1, 1);
    check("after_fa", out, 8'hFA);
    send_frame(8'h0F, 1'b1, 1);
    check("b2b_0f", out, 8'h0F);
    send_frame(8'hF0, 1'b1, 1);
    check("b2b_f0", out, 8'hF0);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_out);
      send_frame(W'($urandom), $urandom_range(0, 9) != 0, $urandom_range(1, 4));
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_out);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
